// File: rtl/uart_tx_feed_fifo.sv
// Byte FIFO and launch sequencer feeding a UART transmitter.
// Ports: host push side, FIFO status, tx handshake, data_input/tx_start.
module uart_tx_feed_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              tx_active,
  input  logic              tx_done,
  output logic [DATA_W-1:0] data_input,
  output logic              tx_start,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_ACT,
    WAIT_DONE
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_nxt;

  logic flush;
  logic pop;
  logic push;

  assign flush = !rst || clear;
  // The sequencer only ever pops from IDLE, and only when data exists.
  assign pop   = (state == IDLE) && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push  = wr_en && (!full || pop);

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
      if (wr_en && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  // The launched byte stays on data_input until the next pop.
  always_ff @(posedge clk) begin
    if (flush) begin
      data_input <= '0;
    end else if (pop) begin
      data_input <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        state_nxt = WAIT_ACT;
      end
      WAIT_ACT: begin
        // A frame short enough to finish before active is
        // seen reports only done; treat it as complete.
        if (tx_active) begin
          state_nxt = WAIT_DONE;
        end else if (tx_done) begin
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        if (tx_done && !tx_active) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    tx_start = (state == LOAD);
    busy     = (state != IDLE);
  end

endmodule

// File: tb/tb_uart_tx_feed_fifo.sv
// Bench for uart_tx_feed_fifo with a behavioural UART model.
// Expected bytes queue on push and are checked at each tx_start.
module tb_uart_tx_feed_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       tx_active;
  logic       tx_done;
  logic [7:0] data_input;
  logic       tx_start;
  logic       busy;

  int n_cmp = 0;
  int n_mis = 0;
  int starts = 0;
  int frame_len = 10;
  bit hang = 1'b0;
  bit abort = 1'b0;

  logic [7:0] exp_q [$];

  uart_tx_feed_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .tx_active  (tx_active),
    .tx_done    (tx_done),
    .data_input (data_input),
    .tx_start   (tx_start),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // UART model: captures each launch, checks it against the
  // scoreboard, then runs a frame of frame_len cycles.
  initial begin
    logic [7:0] cur;
    logic [7:0] e;
    int k;
    tx_active = 1'b0;
    tx_done   = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        starts++;
        cur = data_input;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_mis++;
          $display("FAIL uart_start: got start with %h, required none",
                   cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_mis++;
            $display("FAIL uart_byte: got %h, required %h", cur, e);
          end
        end
        tx_active = 1'b1;
        k = 0;
        while ((hang || k < frame_len) && !abort) begin
          @(negedge clk);
          k++;
          n_cmp++;
          if (tx_start !== 1'b0) begin
            n_mis++;
            $display("FAIL start_in_frame: got %b, required 0",
                     tx_start);
          end
          if (!abort) begin
            n_cmp++;
            if (data_input !== cur) begin
              n_mis++;
              $display("FAIL data_hold: got %h, required %h",
                       data_input, cur);
            end
          end
        end
        tx_active = 1'b0;
        if (!abort) begin
          tx_done = 1'b1;
          @(negedge clk);
          tx_done = 1'b0;
        end
      end
    end
  end

  task automatic push_one(input logic [7:0] b);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic push_run(input logic [7:0] b0, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = b0 + 8'(i);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int c;
    c = 0;
    while (!(busy === 1'b0 && empty === 1'b1 &&
             exp_q.size() == 0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (c >= budget) begin
      n_mis++;
      $display("FAIL %s_timeout: got %0d left, required 0",
               name, exp_q.size());
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0 || empty !== 1'b1) begin
      n_mis++;
      $display("FAIL clear: got ovf=%b empty=%b, required 0/1",
               overflow, empty);
    end
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    clear   = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({empty, count, overflow, tx_start, data_input, busy}
        !== {1'b1, 5'd0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      n_mis++;
      $display("FAIL reset: got e=%b c=%0d o=%b s=%b d=%h b=%b",
               empty, count, overflow, tx_start, data_input, busy);
    end
    @(negedge clk);
    wr_en = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      n_mis++;
      $display("FAIL reset_after: got e=%b c=%0d, required 1/0",
               empty, count);
    end
  endtask

  task automatic test_single();
    frame_len = 10;
    exp_q.push_back(8'hAA);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 8'hAA;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    n_cmp++;
    if (tx_start !== 1'b0 || empty !== 1'b0 || count !== 5'd1) begin
      n_mis++;
      $display("FAIL single_stored: got s=%b e=%b c=%0d",
               tx_start, empty, count);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (tx_start !== 1'b1 || data_input !== 8'hAA ||
        count !== 5'd0 || busy !== 1'b1) begin
      n_mis++;
      $display("FAIL single_launch: got s=%b d=%h c=%0d b=%b",
               tx_start, data_input, count, busy);
    end
    wait_idle(100, "single");
    n_cmp++;
    if (busy !== 1'b0 || empty !== 1'b1) begin
      n_mis++;
      $display("FAIL single_end: got b=%b e=%b, required 0/1",
               busy, empty);
    end
  endtask

  task automatic test_ordering();
    logic [7:0] seq [6];
    int s0;
    seq = '{8'h7F, 8'hAA, 8'h6D, 8'h55, 8'hE2, 8'h1D};
    frame_len = 20;
    s0 = starts;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(seq[i]);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = seq[i];
    end
    @(negedge clk);
    wr_en = 1'b0;
    wait_idle(1000, "ordering");
    n_cmp++;
    if (starts - s0 != 6) begin
      n_mis++;
      $display("FAIL ordering_starts: got %0d, required 6",
               starts - s0);
    end
  endtask

  task automatic test_full_overflow();
    hang = 1'b1;
    exp_q.push_back(8'h40);
    push_one(8'h40);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (count !== 5'd0 || busy !== 1'b1) begin
      n_mis++;
      $display("FAIL full_inflight: got c=%0d b=%b, required 0/1",
               count, busy);
    end
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'h41 + 8'(i));
    end
    push_run(8'h41, 15);
    n_cmp++;
    if (count !== 5'd15 || full !== 1'b0) begin
      n_mis++;
      $display("FAIL full_15: got c=%0d f=%b, required 15/0",
               count, full);
    end
    push_one(8'h50);
    n_cmp++;
    if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
      n_mis++;
      $display("FAIL full_16: got c=%0d f=%b o=%b, required 16/1/0",
               count, full, overflow);
    end
    push_one(8'hEE);
    n_cmp++;
    if (count !== 5'd16 || overflow !== 1'b1) begin
      n_mis++;
      $display("FAIL overflow: got c=%0d o=%b, required 16/1",
               count, overflow);
    end
    frame_len = 3;
    hang = 1'b0;
    wait_idle(800, "full_drain");
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_mis++;
      $display("FAIL overflow_sticky: got %b, required 1", overflow);
    end
  endtask

  task automatic test_wrap_stream();
    int i;
    int cyc;
    int coincide;
    frame_len = 2;
    i = 0;
    cyc = 0;
    coincide = 0;
    while (i < 40 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      n_cmp++;
      if (count > 5'd16) begin
        n_mis++;
        $display("FAIL wrap_count: got %0d, required <=16", count);
      end
      if (full !== 1'b1 || busy !== 1'b1) begin
        if (full === 1'b1) begin
          coincide++;
        end
        wr_en   = 1'b1;
        wr_data = 8'(i);
        exp_q.push_back(8'(i));
        i++;
      end else begin
        wr_en = 1'b0;
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
    n_cmp++;
    if (i != 40) begin
      n_mis++;
      $display("FAIL wrap_pushed: got %0d, required 40", i);
    end
    n_cmp++;
    if (coincide == 0) begin
      n_mis++;
      $display("FAIL wrap_coincide: got %0d, required >0", coincide);
    end
    wait_idle(3000, "wrap");
  endtask

  task automatic test_mid_clear();
    int s0;
    hang = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(8'hC0 + 8'(i));
    end
    push_run(8'hC0, 6);
    repeat (6) @(negedge clk);
    n_cmp++;
    if (count !== 5'd5 || busy !== 1'b1) begin
      n_mis++;
      $display("FAIL clear_pre: got c=%0d b=%b, required 5/1",
               count, busy);
    end
    @(negedge clk);
    abort = 1'b1;
    clear = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, empty, count, tx_start, data_input}
        !== {1'b0, 1'b1, 5'd0, 1'b0, 8'h00}) begin
      n_mis++;
      $display("FAIL clear_post: got b=%b e=%b c=%0d s=%b d=%h",
               busy, empty, count, tx_start, data_input);
    end
    @(negedge clk);
    clear = 1'b0;
    hang  = 1'b0;
    s0 = starts;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (starts != s0) begin
      n_mis++;
      $display("FAIL clear_quiet: got %0d starts, required 0",
               starts - s0);
    end
    abort = 1'b0;
    frame_len = 4;
    exp_q.push_back(8'h3C);
    push_one(8'h3C);
    wait_idle(200, "clear_resume");
    n_cmp++;
    if (starts != s0 + 1) begin
      n_mis++;
      $display("FAIL clear_resume: got %0d starts, required 1",
               starts - s0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ordering();
    test_full_overflow();
    do_clear();
    test_wrap_stream();
    test_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
